tdr_readout: RTL and testbench

- Downstream consumer of the time-domain-register carry latches; one block serves a bank of N latches.
- Arms the bank by releasing the latch reset, waits a capture window, then synchronizes the carry thermometer into clk.
- Converts the thermometer code to a binary count and flags bubbles.
- Presents the result on a valid/ready interface, then clears the bank for the next measurement.

---
 rtl/tdr_pkg.sv | 51 +++++
 rtl/tdr_sync.sv | 22 ++
 rtl/tdr_readout.sv | 127 ++++++++++++
 tb/tb_tdr_readout.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/tdr_pkg.sv
// Shared types and helpers for the TDR carry-latch readout.
// Helpers operate on a vector zero-extended to MAX_LATCH bits; banks wider
// than MAX_LATCH are not supported.
package tdr_pkg;

  localparam int unsigned MAX_LATCH  = 256;
  localparam int unsigned MAX_CODE_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SETTLE,
    CAPTURE,
    HOLD,
    CLEAR
  } state_e;

  // Bits needed to hold a count of 0..n
  function automatic int unsigned code_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Number of set carries
  function automatic logic [MAX_CODE_W-1:0] popcount(input logic [MAX_LATCH-1:0] v);
    logic [MAX_CODE_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < MAX_LATCH; i++) begin
      sum = sum + MAX_CODE_W'(v[i]);
    end
    return sum;
  endfunction

  // A set carry above any cleared carry breaks the thermometer
  function automatic logic bubble_detect(input logic [MAX_LATCH-1:0] v);
    logic seen_zero;
    logic bub;
    seen_zero = 1'b0;
    bub       = 1'b0;
    for (int i = 0; i < MAX_LATCH; i++) begin
      if (v[i] && seen_zero) bub = 1'b1;
      if (!v[i]) seen_zero = 1'b1;
    end
    return bub;
  endfunction

  // Binary to reflected Gray
  function automatic logic [MAX_CODE_W-1:0] gray_encode(input logic [MAX_CODE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/tdr_sync.sv
// Multi-flop synchronizer bringing the asynchronous carry vector into clk.
module tdr_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // Shift chain, stage 0 is the only flop that can go metastable
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) stage_q <= '0;
    else       stage_q <= {stage_q[STAGES-2:0], d};
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/tdr_readout.sv
// TDR readout: arms the carry-latch bank, synchronizes the thermometer,
// converts it to a count with bubble flag and hands it off via valid/ready.
// Optional: define TDR_READOUT_GRAY_EN to present out_code Gray-encoded.
// The latches stay released from ARM until the result is accepted and are
// only pulled back into reset in CLEAR.
module tdr_readout
  import tdr_pkg::*;
#(
  parameter int unsigned N_LATCH     = 16,
  parameter int unsigned WINDOW      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CLR_CYCLES  = 2
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            start,
  input  logic [N_LATCH-1:0]              carry_in,
  output logic                            lat_rstb,
  output logic                            busy,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [code_width(N_LATCH)-1:0]  out_code,
  output logic                            out_bubble
);

  localparam int unsigned CODE_W    = code_width(N_LATCH);
  localparam int unsigned CNT_MAX_A = (WINDOW > SYNC_STAGES) ? WINDOW : SYNC_STAGES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > CLR_CYCLES) ? CNT_MAX_A : CLR_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  lat_rstb_d, busy_d, valid_d, bubble_d;
  logic [CODE_W-1:0]     code_d;
  logic [N_LATCH-1:0]    carry_sync;
  logic [MAX_LATCH-1:0]  sync_ext;
  logic [MAX_CODE_W-1:0] count_bin;

  tdr_sync #(
    .WIDTH  (N_LATCH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rstb (rstb),
    .d    (carry_in),
    .q    (carry_sync)
  );

  assign sync_ext  = MAX_LATCH'(carry_sync);
  assign count_bin = popcount(sync_ext);

  // State register, phase counter and registered outputs
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_rstb   <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_code   <= '0;
      out_bubble <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_rstb   <= lat_rstb_d;
      busy       <= busy_d;
      out_valid  <= valid_d;
      out_code   <= code_d;
      out_bubble <= bubble_d;
    end
  end

  // Next state, counter reloads and next output values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = out_code;
    bubble_d = out_bubble;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          cnt_d   = CNT_W'(WINDOW - 1);
        end
      end
      ARM: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(SYNC_STAGES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = CAPTURE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      CAPTURE: begin
        state_d  = HOLD;
`ifdef TDR_READOUT_GRAY_EN
        code_d   = CODE_W'(gray_encode(count_bin));
`else
        code_d   = CODE_W'(count_bin);
`endif
        bubble_d = bubble_detect(sync_ext);
      end
      HOLD: begin
        if (out_ready) begin
          state_d = CLEAR;
          cnt_d   = CNT_W'(CLR_CYCLES - 1);
        end
      end
      CLEAR: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    lat_rstb_d = (state_d == ARM) || (state_d == SETTLE) ||
                 (state_d == CAPTURE) || (state_d == HOLD);
    busy_d     = (state_d != IDLE);
    valid_d    = (state_d == HOLD);
  end

endmodule

// File: tb/tb_tdr_readout.sv
// Directed scoreboard bench for tdr_readout with default parameters.
module tb_tdr_readout;

  localparam int unsigned N_LATCH     = 16;
  localparam int unsigned WINDOW      = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CLR_CYCLES  = 2;
  localparam int unsigned CODE_W      = $clog2(N_LATCH + 1);
  localparam int          LATENCY     = 1 + WINDOW + SYNC_STAGES + 1;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              bubble;
  } exp_t;

  logic               clk = 1'b0;
  logic               rstb;
  logic               start;
  logic               out_ready;
  logic               lat_rstb;
  logic               busy;
  logic               out_valid;
  logic               out_bubble;
  logic [CODE_W-1:0]  out_code;
  logic [N_LATCH-1:0] carry_in;
  logic [N_LATCH-1:0] pattern;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Latch bank model: shows the pattern while released, cleared in reset
  assign carry_in = lat_rstb ? pattern : '0;

  tdr_readout #(
    .N_LATCH     (N_LATCH),
    .WINDOW      (WINDOW),
    .SYNC_STAGES (SYNC_STAGES),
    .CLR_CYCLES  (CLR_CYCLES)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .start      (start),
    .carry_in   (carry_in),
    .lat_rstb   (lat_rstb),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_bubble (out_bubble)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result: monotonic thermometer means v is of the form 2^k-1
  function automatic exp_t model(input logic [N_LATCH-1:0] v);
    exp_t            e;
    logic [N_LATCH:0] w;
    int unsigned     c;
    w        = {1'b0, v};
    c        = $countones(v);
    e.bubble = ((w & (w + (N_LATCH + 1)'(1))) != '0);
`ifdef TDR_READOUT_GRAY_EN
    e.code   = CODE_W'(c ^ (c >> 1));
`else
    e.code   = CODE_W'(c);
`endif
    return e;
  endfunction

  // One measurement; hold_cyc=0 means out_ready is already high at CAPTURE
  task automatic measure(input logic [N_LATCH-1:0] pat, input int hold_cyc,
                         input bit poke, input string tag);
    exp_t exp;
    int   lat;
    exp       = '0;
    pattern   = pat;
    out_ready = (hold_cyc == 0);
    start     = 1'b1;
    sb.push_back(model(pat));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (lat == 3) begin
        check({tag, "_armed"}, 32'(lat_rstb), 32'(1));
        check({tag, "_busy"}, 32'(busy), 32'(1));
        if (poke) start = 1'b1;
      end
    end while (!out_valid && lat < 40);
    check({tag, "_latency"}, 32'(lat), 32'(LATENCY));
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check({tag, "_code"}, 32'(out_code), 32'(exp.code));
      check({tag, "_bubble"}, 32'(out_bubble), 32'(exp.bubble));
    end
    for (int k = 0; k < hold_cyc; k++) begin
      @(negedge clk);
      start = poke && (k == 0);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'(1));
      check({tag, "_hold_code"}, 32'(out_code), 32'(exp.code));
      check({tag, "_hold_bubble"}, 32'(out_bubble), 32'(exp.bubble));
      check({tag, "_hold_lat"}, 32'(lat_rstb), 32'(1));
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_clr0_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_clr0_lat"}, 32'(lat_rstb), 32'(0));
    check({tag, "_clr0_busy"}, 32'(busy), 32'(1));
    check({tag, "_clr0_code"}, 32'(out_code), 32'(exp.code));
    @(negedge clk);
    check({tag, "_clr1_lat"}, 32'(lat_rstb), 32'(0));
    check({tag, "_clr1_busy"}, 32'(busy), 32'(1));
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(busy), 32'(0));
    check({tag, "_idle_lat"}, 32'(lat_rstb), 32'(0));
  endtask

  initial begin
    rstb      = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    pattern   = '0;
    repeat (3) @(negedge clk);
    check("rst_lat", 32'(lat_rstb), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_code", 32'(out_code), 32'(0));
    check("rst_bubble", 32'(out_bubble), 32'(0));
    rstb = 1'b1;
    @(negedge clk);

    measure(16'h00FF, 0, 1'b0, "m00ff");
    measure(16'hFFFF, 0, 1'b0, "mffff");
    measure(16'h0000, 0, 1'b0, "m0000");
    measure(16'h00F7, 0, 1'b0, "m00f7");
    measure(16'h00FF, 20, 1'b0, "hold20");
    measure(16'h000F, 3, 1'b1, "poke");

    // Stray start pulses must not have queued a second measurement
    repeat (5) @(negedge clk);
    check("poke_no_busy", 32'(busy), 32'(0));
    check("poke_no_valid", 32'(out_valid), 32'(0));
    check("poke_sb_empty", 32'(sb.size()), 32'(0));

    // Asynchronous reset in the middle of ARM
    pattern = 16'h00FF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("midarm_lat", 32'(lat_rstb), 32'(1));
    #2 rstb = 1'b0;
    #1;
    check("arst_lat", 32'(lat_rstb), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_valid", 32'(out_valid), 32'(0));
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    measure(16'h00FF, 0, 1'b0, "postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
